am_demod_chain: RTL and testbench

//  1-bit RF AM receive chain: mixes a 1-bit RF stream with an external NCO (sin/cos) to baseband I/Q.

---
 rtl/am_demod_chain_if.sv | 27 ++
 rtl/am_demod_chain.sv | 230 +++++++++++++++++++++++
 tb/tb_am_demod_chain.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/am_demod_chain_if.sv
// Signal bundle for am_demod_chain: RF/NCO/gain inputs, mixer, decimator and envelope outputs.
interface am_demod_chain_if #(
  parameter int DATA_W = 16
);
  logic                     RF_in;
  logic signed [DATA_W-1:0] sin;
  logic signed [DATA_W-1:0] cos;
  logic [2:0]               gain;
  logic                     RF_out;
  logic signed [DATA_W-1:0] I_out;
  logic signed [DATA_W-1:0] Q_out;
  logic signed [DATA_W-1:0] xI_out;
  logic signed [DATA_W-1:0] xQ_out;
  logic                     x_tick;
  logic signed [DATA_W-1:0] demod_out;
  logic                     out_tick;

  modport master (
    output RF_in, sin, cos, gain,
    input  RF_out, I_out, Q_out, xI_out, xQ_out, x_tick, demod_out, out_tick
  );

  modport slave (
    input  RF_in, sin, cos, gain,
    output RF_out, I_out, Q_out, xI_out, xQ_out, x_tick, demod_out, out_tick
  );
endinterface

// File: rtl/am_demod_chain.sv
// am_demod_chain: 1-bit RF mixer, twin CIC decimators and AM envelope detector.
// Define AM_DEMOD_DCBLOCK_EN to insert a DC blocker on the envelope (adds one cycle).
module am_demod_chain #(
  parameter int CIC_ORDER  = 3,
  parameter int DECIM_LOG2 = 11,
  parameter int DATA_W     = 16
) (
  input logic             CLK,
  input logic             RST,
  am_demod_chain_if.slave bus
);
  // state   | meaning
  // DM_IDLE | waiting for x_tick
  // DM_MAG  | max/min captured, envelope formed this cycle
  // DM_DCB  | DC blocker update (AM_DEMOD_DCBLOCK_EN builds only)

  localparam int ACC_W  = DATA_W + CIC_ORDER*DECIM_LOG2;
  localparam int SHIFT  = CIC_ORDER*DECIM_LOG2;
  localparam int WIDE_W = ACC_W + 8;
  localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [WIDE_W-1:0] WMAX = {{(WIDE_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] WMIN = {{(WIDE_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W+1:0]        MAG_MAX = {3'b000, {(DATA_W-1){1'b1}}};

  function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] v);
    return (v == SMIN) ? SMAX : -v;
  endfunction

  function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? neg_sat(v) : v;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_gain(input logic signed [ACC_W-1:0] v,
                                                        input logic [2:0] g);
    logic signed [WIDE_W-1:0] w;
    w = {{(WIDE_W-ACC_W){v[ACC_W-1]}}, v};
    w = w <<< g;
    if (w > WMAX) return SMAX;
    if (w < WMIN) return SMIN;
    return w[DATA_W-1:0];
  endfunction

  // Mixer
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.RF_out <= 1'b0;
      bus.I_out  <= '0;
      bus.Q_out  <= '0;
    end else begin
      bus.RF_out <= bus.RF_in;
      bus.I_out  <= bus.RF_in ? bus.cos : neg_sat(bus.cos);
      bus.Q_out  <= bus.RF_in ? bus.sin : neg_sat(bus.sin);
    end
  end

  // Integrators run at full rate; wrap-around is harmless since the combs undo it.
  logic signed [ACC_W-1:0]  integ_i [CIC_ORDER];
  logic signed [ACC_W-1:0]  integ_q [CIC_ORDER];
  logic [DECIM_LOG2-1:0]    dec_cnt;
  logic                     dec_last;

  assign dec_last = &dec_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      dec_cnt <= '0;
      for (int k = 0; k < CIC_ORDER; k++) begin
        integ_i[k] <= '0;
        integ_q[k] <= '0;
      end
    end else begin
      dec_cnt    <= dec_cnt + DECIM_LOG2'(1);
      integ_i[0] <= integ_i[0] + sext_acc(bus.I_out);
      integ_q[0] <= integ_q[0] + sext_acc(bus.Q_out);
      for (int k = 1; k < CIC_ORDER; k++) begin
        integ_i[k] <= integ_i[k] + integ_i[k-1];
        integ_q[k] <= integ_q[k] + integ_q[k-1];
      end
    end
  end

  logic signed [ACC_W-1:0] comb_dly_i [CIC_ORDER];
  logic signed [ACC_W-1:0] comb_dly_q [CIC_ORDER];
  logic signed [ACC_W-1:0] stage_in_i [CIC_ORDER];
  logic signed [ACC_W-1:0] stage_in_q [CIC_ORDER];
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic signed [ACC_W-1:0] scaled_i, scaled_q;

  always_comb begin
    acc_i = integ_i[CIC_ORDER-1];
    acc_q = integ_q[CIC_ORDER-1];
    for (int k = 0; k < CIC_ORDER; k++) begin
      stage_in_i[k] = acc_i;
      stage_in_q[k] = acc_q;
      acc_i = acc_i - comb_dly_i[k];
      acc_q = acc_q - comb_dly_q[k];
    end
    scaled_i = acc_i >>> SHIFT;
    scaled_q = acc_q >>> SHIFT;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.xI_out <= '0;
      bus.xQ_out <= '0;
      bus.x_tick <= 1'b0;
      for (int k = 0; k < CIC_ORDER; k++) begin
        comb_dly_i[k] <= '0;
        comb_dly_q[k] <= '0;
      end
    end else begin
      bus.x_tick <= dec_last;
      if (dec_last) begin
        bus.xI_out <= sat_gain(scaled_i, bus.gain);
        bus.xQ_out <= sat_gain(scaled_q, bus.gain);
        for (int k = 0; k < CIC_ORDER; k++) begin
          comb_dly_i[k] <= stage_in_i[k];
          comb_dly_q[k] <= stage_in_q[k];
        end
      end
    end
  end

  // Envelope sequencing
  typedef enum logic [1:0] {DM_IDLE, DM_MAG, DM_DCB} dm_state_t;
  dm_state_t dm_state, dm_next;
  logic      ld_ab, ld_mag;
`ifdef AM_DEMOD_DCBLOCK_EN
  logic      ld_dcb;
`endif

  always_ff @(posedge CLK) begin
    if (RST) dm_state <= DM_IDLE;
    else     dm_state <= dm_next;
  end

  always_comb begin
    dm_next = dm_state;
    ld_ab   = 1'b0;
    ld_mag  = 1'b0;
`ifdef AM_DEMOD_DCBLOCK_EN
    ld_dcb  = 1'b0;
`endif
    case (dm_state)
      DM_IDLE: if (bus.x_tick) begin
        ld_ab   = 1'b1;
        dm_next = DM_MAG;
      end
      DM_MAG: begin
        ld_mag  = 1'b1;
`ifdef AM_DEMOD_DCBLOCK_EN
        dm_next = DM_DCB;
`else
        dm_next = DM_IDLE;
`endif
      end
      DM_DCB: begin
`ifdef AM_DEMOD_DCBLOCK_EN
        ld_dcb  = 1'b1;
`endif
        dm_next = DM_IDLE;
      end
      default: dm_next = DM_IDLE;
    endcase
  end

  logic [DATA_W-1:0] abs_i, abs_q, mx_q, mn_q;
  logic [DATA_W+1:0] mn3, mag_w;
  logic [DATA_W-1:0] mag_sat;

  assign abs_i   = abs_sat(bus.xI_out);
  assign abs_q   = abs_sat(bus.xQ_out);
  assign mn3     = {2'b00, mn_q} + {1'b0, mn_q, 1'b0};
  assign mag_w   = {2'b00, mx_q} + (mn3 >> 3);
  assign mag_sat = (mag_w > MAG_MAX) ? SMAX : mag_w[DATA_W-1:0];

`ifdef AM_DEMOD_DCBLOCK_EN
  localparam int DCB_W = DATA_W + 3;
  logic signed [DATA_W-1:0] mag_q, m_prev, y_prev, y_shr, dcb_y;
  logic signed [DCB_W-1:0]  dcb_sum;

  function automatic logic signed [DCB_W-1:0] sext_dcb(input logic signed [DATA_W-1:0] v);
    return {{(DCB_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  assign y_shr   = y_prev >>> 8;
  assign dcb_sum = sext_dcb(mag_q) - sext_dcb(m_prev) + sext_dcb(y_prev) - sext_dcb(y_shr);
  assign dcb_y   = (dcb_sum > sext_dcb(SMAX)) ? SMAX :
                   (dcb_sum < sext_dcb(SMIN)) ? SMIN : dcb_sum[DATA_W-1:0];
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      mx_q          <= '0;
      mn_q          <= '0;
      bus.demod_out <= '0;
      bus.out_tick  <= 1'b0;
`ifdef AM_DEMOD_DCBLOCK_EN
      mag_q         <= '0;
      m_prev        <= '0;
      y_prev        <= '0;
`endif
    end else begin
      bus.out_tick <= 1'b0;
      if (ld_ab) begin
        mx_q <= (abs_i >= abs_q) ? abs_i : abs_q;
        mn_q <= (abs_i >= abs_q) ? abs_q : abs_i;
      end
`ifdef AM_DEMOD_DCBLOCK_EN
      if (ld_mag) mag_q <= mag_sat;
      if (ld_dcb) begin
        bus.demod_out <= dcb_y;
        y_prev        <= dcb_y;
        m_prev        <= mag_q;
        bus.out_tick  <= 1'b1;
      end
`else
      if (ld_mag) begin
        bus.demod_out <= mag_sat;
        bus.out_tick  <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_am_demod_chain.sv
// Randomized self-checking bench for am_demod_chain (default build, DC blocker off).
module tb_am_demod_chain;
  localparam int DATA_W     = 16;
  localparam int CIC_ORDER  = 3;
  localparam int DECIM_LOG2 = 6;
  localparam int R          = 1 << DECIM_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  am_demod_chain_if #(.DATA_W(DATA_W)) bus ();

  am_demod_chain #(
    .CIC_ORDER (CIC_ORDER),
    .DECIM_LOG2(DECIM_LOG2),
    .DATA_W    (DATA_W)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int mix_ref(input bit rf, input int c);
    if (rf) return c;
    return clamp16(-c);
  endfunction

  function automatic int env_ref(input int xi, input int xq);
    int a, b, mx, mn;
    a  = clamp16(xi < 0 ? -xi : xi);
    b  = clamp16(xq < 0 ? -xq : xq);
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return clamp16(mx + (3 * mn) / 8);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rf, input int c, input int s, input int g);
    @(negedge clk);
    bus.RF_in = rf;
    bus.cos   = 16'(c);
    bus.sin   = 16'(s);
    bus.gain  = 3'(g);
  endtask

  task automatic wait_xtick(input int limit, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus.x_tick && cyc < limit);
    if (!bus.x_tick) check("xtick_timeout", int'(bus.x_tick), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_RF_out"},    int'(bus.RF_out),    0);
    check({tag, "_I_out"},     int'(bus.I_out),     0);
    check({tag, "_Q_out"},     int'(bus.Q_out),     0);
    check({tag, "_xI_out"},    int'(bus.xI_out),    0);
    check({tag, "_xQ_out"},    int'(bus.xQ_out),    0);
    check({tag, "_x_tick"},    int'(bus.x_tick),    0);
    check({tag, "_demod_out"}, int'(bus.demod_out), 0);
    check({tag, "_out_tick"},  int'(bus.out_tick),  0);
  endtask

  // Hold inputs until the CIC has flushed, then compare decimated and envelope values.
  task automatic settled(input string tag, input bit rf, input int c, input int s, input int g,
                         input int exp_i, input int exp_q, input int exp_env);
    int cyc;
    drive(rf, c, s, g);
    repeat (6) wait_xtick(2 * R, cyc);
    check({tag, "_xI"}, int'(bus.xI_out), exp_i);
    check({tag, "_xQ"}, int'(bus.xQ_out), exp_q);
    check({tag, "_I"},  int'(bus.I_out),  mix_ref(rf, c));
    check({tag, "_Q"},  int'(bus.Q_out),  mix_ref(rf, s));
    step();
    step();
    check({tag, "_otick"}, int'(bus.out_tick),  1);
    check({tag, "_env"},   int'(bus.demod_out), exp_env);
    repeat (5) step();
    check({tag, "_hold"},  int'(bus.demod_out), exp_env);
  endtask

  initial begin
    int cyc;
    bus.RF_in = 1'b1;
    bus.cos   = 16'h4000;
    bus.sin   = 16'h1234;
    bus.gain  = 3'd0;
    repeat (3) step();
    check_zero("rst");

    @(negedge clk) rst = 1'b0;
    wait_xtick(4 * R, cyc);
    check("first_tick", cyc, R);
    step();
    check("xtick_pulse", int'(bus.x_tick), 0);
    check("otick_early", int'(bus.out_tick), 0);
    step();
    check("otick_lat2", int'(bus.out_tick), 1);
    step();
    check("otick_pulse", int'(bus.out_tick), 0);
    wait_xtick(2 * R, cyc);
    check("tick_period", cyc, R - 3);

    for (int i = 0; i < 40; i++) begin
      bit rf;
      int c, s;
      rf = 1'($urandom_range(0, 1));
      c  = int'($urandom_range(0, 65535)) - 32768;
      s  = int'($urandom_range(0, 65535)) - 32768;
      if (i == 0) begin
        rf = 1'b0;
        c  = -32768;
        s  = -32768;
      end
      drive(rf, c, s, 0);
      step();
      check("mix_I",  int'(bus.I_out),  mix_ref(rf, c));
      check("mix_Q",  int'(bus.Q_out),  mix_ref(rf, s));
      check("mix_RF", int'(bus.RF_out), int'(rf));
    end

    settled("dc_pos",   1'b1, 'h4000, 0,      0,  16384, 0,     16384);
    settled("dc_neg",   1'b0, 'h4000, 0,      0, -16384, 0,     16384);
    settled("env_34",   1'b1, 'h3000, 'h4000, 0,  12288, 16384, 20992);
    settled("zero",     1'b1, 0,      0,      0,  0,     0,     0);
    settled("gain_sat", 1'b1, 'h4000, 0,      1,  32767, 0,     32767);
    settled("gain_x2",  1'b1, 'h2000, 0,      1,  16384, 0,     16384);

    for (int i = 0; i < 6; i++) begin
      bit rf;
      int c, s, g, ei, eq;
      rf = 1'($urandom_range(0, 1));
      c  = int'($urandom_range(0, 65535)) - 32768;
      s  = int'($urandom_range(0, 65535)) - 32768;
      g  = int'($urandom_range(0, 3));
      ei = clamp16(mix_ref(rf, c) * (1 << g));
      eq = clamp16(mix_ref(rf, s) * (1 << g));
      settled("rand", rf, c, s, g, ei, eq, env_ref(ei, eq));
    end

    settled("pre_rst", 1'b1, 'h4000, 'h1000, 0, 16384, 4096, 16384 + 1536);
    @(negedge clk) rst = 1'b1;
    step();
    check_zero("midrst");
    @(negedge clk) rst = 1'b0;
    wait_xtick(4 * R, cyc);
    check("rst_tick", cyc, R);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
